// File: rtl/dqn_weight_pkg.sv
// Shared definitions for the DQN weight RAM: layer encodings, address width,
// per-layer word counts and the sweep controller state encoding.
package dqn_weight_pkg;

  localparam int WEIGHT_COUNTER_WIDTH = 11;

  localparam logic [1:0] LAYER_HIDDEN_1 = 2'b01;
  localparam logic [1:0] LAYER_HIDDEN_2 = 2'b10;
  localparam logic [1:0] LAYER_OUTPUT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_e;

  // Each node stores one weight per source node plus a bias word.
  function automatic logic [WEIGHT_COUNTER_WIDTH-1:0] layer_word_count(
    input logic [1:0] layer,
    input int         n_in,
    input int         n_h1,
    input int         n_h2,
    input int         n_out
  );
    int words;
    case (layer)
      LAYER_HIDDEN_1: words = n_h1 * (n_in + 1);
      LAYER_HIDDEN_2: words = n_h2 * (n_h1 + 1);
      LAYER_OUTPUT:   words = n_out * (n_h2 + 1);
      default:        words = 0;
    endcase
    return WEIGHT_COUNTER_WIDTH'(words);
  endfunction

endpackage

// File: rtl/weight_ram_sweep_controller_if.sv
// Weight RAM request/return bus. The sweep controller is the master and the
// RAM is the slave; requests and returns are single-cycle, no back-pressure.
interface weight_ram_sweep_controller_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int LAYER_WIDTH = 2
);
  import dqn_weight_pkg::*;

  logic                            o_ram_enable;
  logic                            o_rw_select;
  logic [LAYER_WIDTH-1:0]          o_weight_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr;
  logic [DATA_WIDTH-1:0]           o_weight;
  logic                            i_weight_valid;
  logic [LAYER_WIDTH-1:0]          i_weight_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr;
  logic [DATA_WIDTH-1:0]           i_weight;

  modport master (
    output o_ram_enable, o_rw_select, o_weight_layer, o_weight_addr, o_weight,
    input  i_weight_valid, i_weight_layer, i_weight_addr, i_weight
  );

  modport slave (
    input  o_ram_enable, o_rw_select, o_weight_layer, o_weight_addr, o_weight,
    output i_weight_valid, i_weight_layer, i_weight_addr, i_weight
  );

endinterface

// File: rtl/weight_addr_counter.sv
// Sweep address counter: load clears the count and captures the last index,
// inc advances it, at_last flags count == last.
module weight_addr_counter
  import dqn_weight_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] load_last,
  input  logic                            inc,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] count,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] last,
  output logic                            at_last
);

  logic [WEIGHT_COUNTER_WIDTH-1:0] count_q, count_d;
  logic [WEIGHT_COUNTER_WIDTH-1:0] last_q, last_d;

  // Saturates instead of wrapping so an overrun can never alias address 0.
  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    if (load) begin
      count_d = '0;
      last_d  = load_last;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WEIGHT_COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      last_q  <= '0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign count   = count_q;
  assign last    = last_q;
  assign at_last = (count_q == last_q);

endmodule

// File: rtl/weight_ram_sweep_controller.sv
// Sweeps every address of one weight-RAM layer, either issuing reads and
// streaming the returns out, or accepting a write stream and issuing writes.
module weight_ram_sweep_controller
  import dqn_weight_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic                            i_mode,
  input  logic [LAYER_WIDTH-1:0]          i_layer,
  input  logic                            i_pause,
  input  logic                            i_wdata_valid,
  input  logic [DATA_WIDTH-1:0]           i_wdata,
  output logic                            o_wdata_ready,
  weight_ram_sweep_controller_if.master   ram,
  output logic                            o_rdata_valid,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_rdata_addr,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic                            o_rdata_last,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error,
  output sweep_state_e                    o_dbg_state
);

  // Handshake: the write stream transfers a word on every rising edge where
  // i_wdata_valid && o_wdata_ready; the read stream has no back-pressure.

  sweep_state_e                    state_q, state_d;
  logic [LAYER_WIDTH-1:0]          layer_q, layer_d;
  logic                            ram_en_q, ram_en_d;
  logic                            rw_q, rw_d;
  logic [LAYER_WIDTH-1:0]          req_layer_q, req_layer_d;
  logic [WEIGHT_COUNTER_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic                            done_q, done_d;
  logic                            error_q, error_d;
  logic                            rvalid_q, rvalid_d;
  logic                            rlast_q, rlast_d;
  logic [WEIGHT_COUNTER_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]           rdata_q, rdata_d;

  logic                            cnt_load;
  logic                            cnt_inc;
  logic [WEIGHT_COUNTER_WIDTH-1:0] cnt_load_last;
  logic [WEIGHT_COUNTER_WIDTH-1:0] cnt;
  logic [WEIGHT_COUNTER_WIDTH-1:0] cnt_last;
  logic                            cnt_at_last;
  logic                            ret_match;

  assign cnt_load_last = layer_word_count(i_layer[1:0], NUMBER_OF_INPUT_NODE,
                                          NUMBER_OF_HIDDEN_NODE_LAYER_1,
                                          NUMBER_OF_HIDDEN_NODE_LAYER_2,
                                          NUMBER_OF_OUTPUT_NODE)
                         - WEIGHT_COUNTER_WIDTH'(1);

  weight_addr_counter u_addr_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_last (cnt_load_last),
    .inc       (cnt_inc),
    .count     (cnt),
    .last      (cnt_last),
    .at_last   (cnt_at_last)
  );

  // Returns are only forwarded while this controller owns a read sweep.
  assign ret_match = ram.i_weight_valid && (ram.i_weight_layer == layer_q) &&
                     ((state_q == ST_READ) || (state_q == ST_DRAIN));

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    ram_en_d    = 1'b0;
    rw_d        = rw_q;
    req_layer_d = req_layer_q;
    req_addr_d  = req_addr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    rvalid_d    = ret_match;
    rlast_d     = ret_match && (ram.i_weight_addr == cnt_last);
    raddr_d     = raddr_q;
    rdata_d     = rdata_q;
    if (ret_match) begin
      raddr_d = ram.i_weight_addr;
      rdata_d = ram.i_weight;
    end
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_layer == '0) begin
            error_d = 1'b1;
          end else begin
            layer_d  = i_layer;
            cnt_load = 1'b1;
            state_d  = i_mode ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_READ: begin
        if (!i_pause) begin
          ram_en_d    = 1'b1;
          rw_d        = 1'b1;
          req_layer_d = layer_q;
          req_addr_d  = cnt;
          cnt_inc     = 1'b1;
          if (cnt_at_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rlast_d) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (i_wdata_valid) begin
          ram_en_d    = 1'b1;
          rw_d        = 1'b0;
          req_layer_d = layer_q;
          req_addr_d  = cnt;
          wdata_d     = i_wdata;
          cnt_inc     = 1'b1;
          if (cnt_at_last) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      ram_en_q    <= 1'b0;
      rw_q        <= 1'b0;
      req_layer_q <= '0;
      req_addr_q  <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      raddr_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      ram_en_q    <= ram_en_d;
      rw_q        <= rw_d;
      req_layer_q <= req_layer_d;
      req_addr_q  <= req_addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      raddr_q     <= raddr_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ram.o_ram_enable   = ram_en_q;
  assign ram.o_rw_select    = rw_q;
  assign ram.o_weight_layer = req_layer_q;
  assign ram.o_weight_addr  = req_addr_q;
  assign ram.o_weight       = wdata_q;

  assign o_wdata_ready = (state_q == ST_WRITE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_rdata_valid = rvalid_q;
  assign o_rdata_last  = rlast_q;
  assign o_rdata_addr  = raddr_q;
  assign o_rdata       = rdata_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_weight_ram_sweep_controller.sv
// Directed bench for weight_ram_sweep_controller: expected RAM requests and
// read-stream words are queued by the stimulus and popped by a monitor.
module tb_weight_ram_sweep_controller;
  import dqn_weight_pkg::*;

  localparam int DW = 32;
  localparam int REQ_W = 1 + 2 + WEIGHT_COUNTER_WIDTH + DW;
  localparam int RD_W  = 1 + WEIGHT_COUNTER_WIDTH + DW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                            i_start, i_mode, i_pause, i_wdata_valid;
  logic [1:0]                      i_layer;
  logic [DW-1:0]                   i_wdata;
  logic                            o_wdata_ready, o_rdata_valid, o_rdata_last;
  logic [WEIGHT_COUNTER_WIDTH-1:0] o_rdata_addr;
  logic [DW-1:0]                   o_rdata;
  logic                            o_busy, o_done, o_error;
  sweep_state_e                    o_dbg_state;

  weight_ram_sweep_controller_if #(.DATA_WIDTH(DW), .LAYER_WIDTH(2)) ram_if ();

  weight_ram_sweep_controller dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .i_layer       (i_layer),
    .i_pause       (i_pause),
    .i_wdata_valid (i_wdata_valid),
    .i_wdata       (i_wdata),
    .o_wdata_ready (o_wdata_ready),
    .ram           (ram_if.master),
    .o_rdata_valid (o_rdata_valid),
    .o_rdata_addr  (o_rdata_addr),
    .o_rdata       (o_rdata),
    .o_rdata_last  (o_rdata_last),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_dbg_state   (o_dbg_state)
  );

  function automatic logic [DW-1:0] rfn(input logic [1:0] l, input int a);
    logic [WEIGHT_COUNTER_WIDTH-1:0] a11;
    a11 = WEIGHT_COUNTER_WIDTH'(a);
    return {4'hA, 2'b00, l, 13'h0, a11};
  endfunction

  function automatic logic [DW-1:0] wfn(input int a);
    return 32'h5A00_0000 + DW'(a * 3);
  endfunction

  // Fixed 1-cycle latency RAM model returning a layer/address signature.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_if.i_weight_valid <= 1'b0;
      ram_if.i_weight_layer <= '0;
      ram_if.i_weight_addr  <= '0;
      ram_if.i_weight       <= '0;
    end else begin
      ram_if.i_weight_valid <= ram_if.o_ram_enable && ram_if.o_rw_select;
      ram_if.i_weight_layer <= ram_if.o_weight_layer;
      ram_if.i_weight_addr  <= ram_if.o_weight_addr;
      ram_if.i_weight       <= rfn(ram_if.o_weight_layer, int'(ram_if.o_weight_addr));
    end
  end

  // ---------------- scoreboard ----------------
  logic [REQ_W-1:0] req_q[$];
  logic [RD_W-1:0]  rd_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, en_cnt = 0, rv_cnt = 0;
  int first_issue = -1, first_rv = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_if.o_ram_enable) begin
        en_cnt++;
        if (first_issue < 0) first_issue = cyc;
        if (req_q.size() == 0) begin
          check("ram_req_unexpected", {ram_if.o_rw_select, ram_if.o_weight_addr}, 64'hFFFF_FFFF);
        end else begin
          check("ram_req",
                {ram_if.o_rw_select, ram_if.o_weight_layer, ram_if.o_weight_addr,
                 ram_if.o_rw_select ? 32'h0 : ram_if.o_weight},
                req_q.pop_front());
        end
      end
      if (o_rdata_valid) begin
        rv_cnt++;
        if (first_rv < 0) first_rv = cyc;
        if (rd_q.size() == 0)
          check("rdata_unexpected", {o_rdata_last, o_rdata_addr}, 64'hFFFF_FFFF);
        else
          check("rdata", {o_rdata_last, o_rdata_addr, o_rdata}, rd_q.pop_front());
      end
      if (o_rdata_last) check("done_with_last", o_done, 1);
      if (o_done) done_cnt++;
      if (o_error) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic mode, input logic [1:0] layer);
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = mode; i_layer = layer;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_req_addr(input int addr, input string tag);
    int n = 0;
    while (!(ram_if.o_ram_enable && ram_if.o_weight_addr == WEIGHT_COUNTER_WIDTH'(addr)) && n < 2000) begin
      @(negedge clk); n++;
    end
    check({tag, "_reach_addr"}, n < 2000, 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!o_done && n < budget) begin
      @(negedge clk); n++;
    end
    check({tag, "_done_timeout"}, n < budget, 1);
  endtask

  task automatic read_sweep(input logic [1:0] layer, input int n, input int pause_at,
                            input int inject_at, input string tag);
    int d0, e0;
    for (int a = 0; a < n; a++) begin
      req_q.push_back({1'b1, layer, WEIGHT_COUNTER_WIDTH'(a), 32'h0});
      rd_q.push_back({a == n - 1, WEIGHT_COUNTER_WIDTH'(a), rfn(layer, a)});
    end
    rv_cnt = 0; first_issue = -1; first_rv = -1;
    d0 = done_cnt; e0 = err_cnt;
    start_cmd(1'b1, layer);
    if (pause_at >= 0) begin
      wait_req_addr(pause_at - 1, tag);
      i_pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check({tag, "_paused_no_issue"}, ram_if.o_ram_enable, 0);
        if (i == 1) check({tag, "_inflight_delivered"}, {o_rdata_valid, o_rdata_addr},
                          {1'b1, WEIGHT_COUNTER_WIDTH'(pause_at - 1)});
      end
      i_pause = 1'b0;
    end
    if (inject_at >= 0) begin
      wait_req_addr(inject_at, tag);
      start_cmd(1'b0, 2'b11);
    end
    wait_done(3000, tag);
    check({tag, "_last_addr"}, {o_rdata_last, o_rdata_addr}, {1'b1, WEIGHT_COUNTER_WIDTH'(n - 1)});
    @(negedge clk);
    check({tag, "_busy_drop"}, o_busy, 0);
    check({tag, "_word_count"}, rv_cnt, n);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_no_error"}, err_cnt - e0, 0);
    check({tag, "_req_q_empty"}, req_q.size(), 0);
    check({tag, "_rd_q_empty"}, rd_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent, guard, d0, e0, n0;
    logic phase;
    rst = 1'b1; i_start = 0; i_mode = 0; i_layer = 0; i_pause = 0;
    i_wdata_valid = 0; i_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero",
          {ram_if.o_ram_enable, ram_if.o_rw_select, ram_if.o_weight_layer, o_wdata_ready,
           o_rdata_valid, o_rdata_last, o_busy, o_done, o_error}, 0);
    check("reset_req_addr", ram_if.o_weight_addr, 0);
    check("reset_req_data", ram_if.o_weight, 0);
    check("reset_rdata", {o_rdata_addr, o_rdata}, 0);
    check("reset_state_idle", o_dbg_state, ST_IDLE);
    rst = 1'b0;

    // Read sweep of hidden layer 1, plus issue-to-valid latency.
    read_sweep(2'b01, 96, -1, -1, "t1_read_h1");
    check("t1_latency", first_rv - first_issue, 2);

    // Write sweep of the output layer with valid toggling 1010...
    for (int a = 0; a < 99; a++) req_q.push_back({1'b0, 2'b11, WEIGHT_COUNTER_WIDTH'(a), wfn(a)});
    d0 = done_cnt; sent = 0; guard = 0; phase = 1'b1;
    start_cmd(1'b0, 2'b11);
    while (sent < 99 && guard < 1000) begin
      @(posedge clk); #1;
      i_wdata_valid = phase; i_wdata = wfn(sent);
      phase = ~phase;
      @(negedge clk);
      if (i_wdata_valid && o_wdata_ready) sent++;
      guard++;
    end
    check("t2_write_timeout", guard < 1000, 1);
    @(posedge clk); #1;
    i_wdata_valid = 1'b0;
    @(negedge clk);
    check("t2_ready_low_after_last", o_wdata_ready, 0);
    check("t2_done_pulse", o_done, 1);
    repeat (3) @(negedge clk);
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_req_q_empty", req_q.size(), 0);

    // Read sweep of hidden layer 2 with a 5-cycle pause at address 500.
    read_sweep(2'b10, 1056, 500, -1, "t3_read_h2_pause");

    // Layer 00 is rejected.
    e0 = err_cnt; n0 = en_cnt;
    start_cmd(1'b1, 2'b00);
    @(negedge clk);
    check("t4_error_pulse", o_error, 1);
    check("t4_busy_low", o_busy, 0);
    @(negedge clk);
    check("t4_error_clears", o_error, 0);
    repeat (4) @(negedge clk);
    check("t4_error_once", err_cnt - e0, 1);
    check("t4_no_ram_traffic", en_cnt - n0, 0);
    check("t4_still_idle", o_busy, 0);

    // A start during an active sweep is ignored.
    read_sweep(2'b01, 96, -1, 20, "t5_restart_ignored");

    // Reset at read address 40 abandons the sweep.
    for (int a = 0; a <= 40; a++) req_q.push_back({1'b1, 2'b01, WEIGHT_COUNTER_WIDTH'(a), 32'h0});
    for (int a = 0; a <= 38; a++) rd_q.push_back({1'b0, WEIGHT_COUNTER_WIDTH'(a), rfn(2'b01, a)});
    d0 = done_cnt;
    start_cmd(1'b1, 2'b01);
    wait_req_addr(40, "t6_reset");
    #1; rst = 1'b1; #1;
    check("t6_reset_enable_drop", ram_if.o_ram_enable, 0);
    check("t6_reset_outputs_zero", {o_busy, o_rdata_valid, o_done, o_wdata_ready}, 0);
    check("t6_reset_addr_zero", ram_if.o_weight_addr, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_req_q_empty", req_q.size(), 0);
    check("t6_rd_q_empty", rd_q.size(), 0);
    check("t6_idle_after_reset", o_dbg_state, ST_IDLE);
    read_sweep(2'b01, 96, -1, -1, "t6_restart_from_zero");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
